uart_echo_fifo: RTL and testbench

Self-contained UART echo engine: a parametrised receiver and transmitter joined by a synchronous FIFO, so bursts of back-to-back received bytes are buffered and echoed rather than lost. It replaces the unbuffered RX→TX loopback at the board top level. It adds configurable data width, transmit flow control, sticky overrun and framing-error flags, and an optional even-parity bit. Single clock domain; the RX pin is synchronised internally.

---
 rtl/uart_echo_fifo_if.sv | 20 ++
 rtl/uart_echo_fifo.sv | 172 +++++++++++++++++
 tb/tb_uart_echo_fifo.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_echo_fifo_if.sv
// uart_echo_fifo_if: serial pins, TX flow control and status flags of the UART echo engine.
interface uart_echo_fifo_if #(
  parameter int CW = 5
);
  logic i_UART_RX;
  logic i_TX_Pause;
  logic o_UART_TX;
  logic o_TX_Active;
  logic [CW-1:0] o_FIFO_Count;
  logic o_Overrun;
  logic o_Frame_Err;
  modport master (
    output i_UART_RX, i_TX_Pause,
    input o_UART_TX, o_TX_Active, o_FIFO_Count, o_Overrun, o_Frame_Err
  );
  modport slave (
    input i_UART_RX, i_TX_Pause,
    output o_UART_TX, o_TX_Active, o_FIFO_Count, o_Overrun, o_Frame_Err
  );
endinterface

// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: UART RX -> FIFO -> UART TX echo with pause, overrun and framing flags.
// Define UART_PARITY_EN to add an even-parity bit to both directions.
module uart_echo_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS = 8,
  parameter int FIFO_DEPTH = 16
) (
  input logic i_Clk,
  input logic i_Rst,
  uart_echo_fifo_if.slave u
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] BIT_END = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic rx_perr_q, tx_par_q;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t rx_st_q, tx_st_q;
  logic rx_s1_q, rx_s2_q, rx_prev_q;
  logic [TW-1:0] rx_cnt_q, tx_cnt_q;
  logic [IW-1:0] rx_idx_q, tx_idx_q;
  logic [DATA_BITS-1:0] rx_sh_q, tx_sh_q;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] count_q;
  logic tx_q, active_q, ovr_q, ferr_q;
  logic rx_ok, push, pop, accept;
`ifdef UART_PARITY_EN
  assign rx_ok = rx_s2_q && !rx_perr_q;
`else
  assign rx_ok = rx_s2_q;
`endif
  assign push = rx_st_q == STOP && rx_cnt_q == BIT_END && rx_ok;
  assign pop = tx_st_q == IDLE && count_q != '0 && !u.i_TX_Pause;
  // a full FIFO still takes the byte when TX frees a slot in the same cycle
  assign accept = push && (count_q != (AW+1)'(FIFO_DEPTH) || pop);
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_st_q <= IDLE;
      rx_cnt_q <= '0;
      rx_idx_q <= '0;
      rx_sh_q <= '0;
      ferr_q <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr_q <= 1'b0;
`endif
    end else begin
      rx_s1_q <= u.i_UART_RX;
      rx_s2_q <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_cnt_q <= rx_cnt_q + 1'b1;
      case (rx_st_q)
        IDLE: begin
          rx_cnt_q <= '0;
          if (rx_prev_q && !rx_s2_q) rx_st_q <= START;
        end
        START: if (rx_cnt_q == HALF_END) begin
          rx_cnt_q <= '0;
          rx_idx_q <= '0;
          rx_st_q <= rx_s2_q ? IDLE : DATA;
        end
        DATA: if (rx_cnt_q == BIT_END) begin
          rx_cnt_q <= '0;
          rx_sh_q <= {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
          rx_idx_q <= rx_idx_q + 1'b1;
`ifdef UART_PARITY_EN
          if (rx_idx_q == LAST_BIT) rx_st_q <= PARITY;
`else
          if (rx_idx_q == LAST_BIT) rx_st_q <= STOP;
`endif
        end
`ifdef UART_PARITY_EN
        PARITY: if (rx_cnt_q == BIT_END) begin
          rx_cnt_q <= '0;
          rx_perr_q <= rx_s2_q ^ (^rx_sh_q);
          rx_st_q <= STOP;
        end
`endif
        STOP: if (rx_cnt_q == BIT_END) begin
          rx_st_q <= IDLE;
          if (!rx_ok) ferr_q <= 1'b1;
        end
        default: rx_st_q <= IDLE;
      endcase
    end
  end
  always_ff @(posedge i_Clk) if (accept) mem_q[wp_q] <= rx_sh_q;
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wp_q <= '0;
      rp_q <= '0;
      count_q <= '0;
      ovr_q <= 1'b0;
      tx_st_q <= IDLE;
      tx_cnt_q <= '0;
      tx_idx_q <= '0;
      tx_sh_q <= '0;
      tx_q <= 1'b1;
      active_q <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_q <= 1'b0;
`endif
    end else begin
      if (accept) wp_q <= wp_q + 1'b1;
      if (push && !accept) ovr_q <= 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      count_q <= count_q + (AW+1)'(accept) - (AW+1)'(pop);
      tx_cnt_q <= tx_cnt_q + 1'b1;
      case (tx_st_q)
        IDLE: begin
          tx_cnt_q <= '0;
          if (pop) begin
            tx_sh_q <= mem_q[rp_q];
`ifdef UART_PARITY_EN
            tx_par_q <= ^mem_q[rp_q];
`endif
            tx_q <= 1'b0;
            active_q <= 1'b1;
            tx_st_q <= START;
          end
        end
        START: if (tx_cnt_q == BIT_END) begin
          tx_cnt_q <= '0;
          tx_idx_q <= '0;
          tx_q <= tx_sh_q[0];
          tx_st_q <= DATA;
        end
        DATA: if (tx_cnt_q == BIT_END) begin
          tx_cnt_q <= '0;
          tx_idx_q <= tx_idx_q + 1'b1;
          tx_sh_q <= tx_sh_q >> 1;
          if (tx_idx_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
            tx_q <= tx_par_q;
            tx_st_q <= PARITY;
`else
            tx_q <= 1'b1;
            tx_st_q <= STOP;
`endif
          end else tx_q <= tx_sh_q[1];
        end
`ifdef UART_PARITY_EN
        PARITY: if (tx_cnt_q == BIT_END) begin
          tx_cnt_q <= '0;
          tx_q <= 1'b1;
          tx_st_q <= STOP;
        end
`endif
        STOP: if (tx_cnt_q == BIT_END) begin
          tx_q <= 1'b1;
          active_q <= 1'b0;
          tx_st_q <= IDLE;
        end
        default: tx_st_q <= IDLE;
      endcase
    end
  end
  assign u.o_UART_TX = tx_q;
  assign u.o_TX_Active = active_q;
  assign u.o_FIFO_Count = count_q;
  assign u.o_Overrun = ovr_q;
  assign u.o_Frame_Err = ferr_q;
endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb_uart_echo_fifo: directed checks of the UART echo FIFO; parity cases run when UART_PARITY_EN is defined.
module tb_uart_echo_fifo;
  localparam int CPB = 16;
`ifdef UART_PARITY_EN
  localparam int FB = 11;
  logic bad_par = 1'b0;
  logic par_q[$];
`else
  localparam int FB = 10;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int rst_gen = 0;
  logic [7:0] echo_q[$];
  int start_q[$];
  uart_echo_fifo_if #(.CW(3)) u ();
  uart_echo_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .FIFO_DEPTH(4)) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .u(u.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] d, input logic stop);
    u.i_UART_RX = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      u.i_UART_RX = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    u.i_UART_RX = (^d) ^ bad_par;
    repeat (CPB) @(negedge clk);
`endif
    u.i_UART_RX = stop;
    repeat (CPB) @(negedge clk);
    u.i_UART_RX = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic wait_echo(input int n, input string tag);
    int k = 0;
    while (echo_q.size() < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check(tag, echo_q.size(), n);
  endtask
  task automatic lat_check();
    int k = 0;
    while (u.o_FIFO_Count != 3'd1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("a5_push_seen", k < 400, 1);
    check("a5_tx_idle_at_push", u.o_UART_TX, 1);
    @(negedge clk);
    check("a5_start_lat", u.o_UART_TX, 0);
    check("a5_active", u.o_TX_Active, 1);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx"}, u.o_UART_TX, 1);
    check({tag, "_active"}, u.o_TX_Active, 0);
    check({tag, "_count"}, u.o_FIFO_Count, 0);
    check({tag, "_ovr"}, u.o_Overrun, 0);
    check({tag, "_ferr"}, u.o_Frame_Err, 0);
  endtask
  task automatic clear_echo();
    echo_q.delete();
    start_q.delete();
`ifdef UART_PARITY_EN
    par_q.delete();
`endif
  endtask
  // decodes o_UART_TX frames mid-bit; frames cut by reset are dropped
  initial begin : decoder
    logic prev, cur;
    logic [7:0] d;
    int st, g;
`ifdef UART_PARITY_EN
    logic p;
`endif
    prev = 1'b1;
    forever begin
      @(negedge clk);
      cur = u.o_UART_TX;
      if (prev && !cur) begin
        st = cyc;
        g = rst_gen;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = u.o_UART_TX;
        end
`ifdef UART_PARITY_EN
        repeat (CPB) @(negedge clk);
        p = u.o_UART_TX;
`endif
        repeat (CPB) @(negedge clk);
        cur = u.o_UART_TX;
        if (g == rst_gen) begin
          check("echo_stop", cur, 1);
          echo_q.push_back(d);
          start_q.push_back(st);
`ifdef UART_PARITY_EN
          par_q.push_back(p);
`endif
        end
      end
      prev = cur;
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int k;
    u.i_UART_RX = 1'b1;
    u.i_TX_Pause = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    fork
      send_byte(8'hA5, 1'b1);
      lat_check();
    join
    wait_echo(1, "a5_echo_n");
    check("a5_data", echo_q[0], 8'hA5);
    check("a5_count", u.o_FIFO_Count, 0);
    repeat (40) @(negedge clk);
    clear_echo();
    u.i_TX_Pause = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_byte(8'h10 + 8'(i), 1'b1);
      check($sformatf("pause_count_%0d", i), u.o_FIFO_Count, (i < 4) ? i + 1 : 4);
      check($sformatf("pause_ovr_%0d", i), u.o_Overrun, (i >= 4) ? 1 : 0);
    end
    check("pause_active", u.o_TX_Active, 0);
    u.i_TX_Pause = 1'b0;
    wait_echo(4, "pause_echo_n");
    for (int i = 0; i < 4; i++) check($sformatf("pause_data_%0d", i), echo_q[i], 8'h10 + 8'(i));
    for (int i = 0; i < 3; i++) check($sformatf("pause_gap_%0d", i), start_q[i+1] - start_q[i], FB * CPB + 1);
    repeat (400) @(negedge clk);
    check("pause_no_extra", echo_q.size(), 4);
    check("pause_count_end", u.o_FIFO_Count, 0);
    clear_echo();
    u.i_UART_RX = 1'b0;
    repeat (7) @(negedge clk);
    u.i_UART_RX = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch_count", u.o_FIFO_Count, 0);
    check("glitch_echo_n", echo_q.size(), 0);
    check("glitch_ferr", u.o_Frame_Err, 0);
    check("glitch_active", u.o_TX_Active, 0);
    send_byte(8'h3C, 1'b0);
    check("frame_ferr", u.o_Frame_Err, 1);
    repeat (300) @(negedge clk);
    check("frame_echo_n", echo_q.size(), 0);
    send_byte(8'h55, 1'b1);
    wait_echo(1, "frame_55_n");
    check("frame_55_data", echo_q[0], 8'h55);
    check("frame_ferr_sticky", u.o_Frame_Err, 1);
    repeat (40) @(negedge clk);
    clear_echo();
    send_byte(8'h81, 1'b1);
    k = 0;
    while (!u.o_TX_Active && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("rst_tx_started", k < 400, 1);
    repeat (4 * CPB) @(negedge clk);
    rst = 1'b1;
    rst_gen++;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    check("midrst_echo_n", echo_q.size(), 0);
    check("midrst_tx_idle", u.o_UART_TX, 1);
`ifdef UART_PARITY_EN
    clear_echo();
    send_byte(8'h07, 1'b1);
    wait_echo(1, "par_good_n");
    check("par_good_data", echo_q[0], 8'h07);
    check("par_good_bit", par_q[0], 1);
    check("par_good_ferr", u.o_Frame_Err, 0);
    repeat (40) @(negedge clk);
    bad_par = 1'b1;
    send_byte(8'h07, 1'b1);
    bad_par = 1'b0;
    repeat (300) @(negedge clk);
    check("par_bad_ferr", u.o_Frame_Err, 1);
    check("par_bad_echo_n", echo_q.size(), 1);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
